// File: rtl/sdram_arbiter_pkg.sv
// Shared definitions for the two-master SDRAM port arbiter: FSM encodings,
// one-hot grant codes and the default watchdog limit.
package sdram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_G0   = 2'd1,
    ST_G1   = 2'd2,
    ST_REL  = 2'd3
  } state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  localparam logic [7:0] DEF_TIMEOUT = 8'd255;

endpackage

// File: rtl/sdram_arb_wdog.sv
// 8-bit transaction watchdog: counts while enabled, clears on request and
// flags expiry once the count reaches TIMEOUT (then holds there).
module sdram_arb_wdog
  import sdram_arbiter_pkg::*;
#(
  parameter logic [7:0] TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk_p,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [7:0] wdog;

  // NOTE: clocked state uses non-blocking assignment so every flop samples
  // the pre-edge value of its neighbours.
  always_ff @(posedge clk_p or posedge rst) begin
    if (rst)                 wdog <= '0;
    else if (clr)            wdog <= '0;
    else if (en && !expire)  wdog <= wdog + 8'd1;
  end

  assign expire = (wdog == TIMEOUT);

endmodule

// File: rtl/sdram_arbiter.sv
// Two-master arbiter in front of the single SDRAM controller port, one whole
// transaction per grant. Define SDRAM_ARB_RR_EN for round-robin selection.
module sdram_arbiter
  import sdram_arbiter_pkg::*;
#(
  parameter int         AW      = 21,
  parameter int         DW      = 16,
  parameter logic [7:0] TIMEOUT = DEF_TIMEOUT
) (
  input  logic          clk_p,
  input  logic          sdram_reset,
  input  logic          sdram_ready,
  input  logic          m0_stb,
  input  logic          m0_we,
  input  logic [1:0]    m0_sel,
  input  logic [AW:1]   m0_adr,
  input  logic [DW-1:0] m0_out,
  output logic [DW-1:0] m0_dat,
  output logic          m0_ack,
  output logic          m0_err,
  input  logic          m1_stb,
  input  logic          m1_we,
  input  logic [1:0]    m1_sel,
  input  logic [AW:1]   m1_adr,
  input  logic [DW-1:0] m1_out,
  output logic [DW-1:0] m1_dat,
  output logic          m1_ack,
  output logic          m1_err,
  output logic          s_stb,
  output logic          s_we,
  output logic [1:0]    s_sel,
  output logic [AW:1]   s_adr,
  output logic [DW-1:0] s_out,
  input  logic [DW-1:0] s_dat,
  input  logic          s_ack,
  output logic [1:0]    gnt
);

  state_t state, state_nxt;
  logic   in_gnt, wd_expire, abort, pick_m1;

  assign in_gnt = (state == ST_G0) || (state == ST_G1);
  assign s_stb  = ((state == ST_G0) && m0_stb) || ((state == ST_G1) && m1_stb);
  // Ack wins over an expiry landing in the same cycle.
  assign abort  = wd_expire && s_stb && !s_ack;
  assign m0_dat = s_dat;
  assign m1_dat = s_dat;

  sdram_arb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk_p  (clk_p),
    .rst    (sdram_reset),
    .clr    (!in_gnt || s_ack),
    .en     (s_stb && !s_ack),
    .expire (wd_expire)
  );

`ifdef SDRAM_ARB_RR_EN
  logic last;

  always_ff @(posedge clk_p or posedge sdram_reset) begin
    if (sdram_reset)                                 last <= 1'b1;
    else if (state == ST_IDLE && state_nxt == ST_G0) last <= 1'b0;
    else if (state == ST_IDLE && state_nxt == ST_G1) last <= 1'b1;
  end

  // On a tie the master that did not win last time goes first.
  assign pick_m1 = m1_stb && (!m0_stb || !last);
`else
  assign pick_m1 = m1_stb && !m0_stb;
`endif

  always_ff @(posedge clk_p or posedge sdram_reset) begin
    if (sdram_reset) state <= ST_IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    state_nxt = state;
    gnt       = GNT_NONE;
    s_we      = 1'b0;
    s_sel     = '0;
    s_adr     = '0;
    s_out     = '0;
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    m0_err    = 1'b0;
    m1_err    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sdram_ready && (m0_stb || m1_stb))
          state_nxt = pick_m1 ? ST_G1 : ST_G0;
      end
      ST_G0: begin
        gnt    = GNT_M0;
        s_we   = m0_we;
        s_sel  = m0_sel;
        s_adr  = m0_adr;
        s_out  = m0_out;
        m0_ack = s_ack && m0_stb;
        m0_err = abort;
        if (!m0_stb || abort) state_nxt = ST_REL;
      end
      ST_G1: begin
        gnt    = GNT_M1;
        s_we   = m1_we;
        s_sel  = m1_sel;
        s_adr  = m1_adr;
        s_out  = m1_out;
        m1_ack = s_ack && m1_stb;
        m1_err = abort;
        if (!m1_stb || abort) state_nxt = ST_REL;
      end
      // One forced idle stb cycle lets the controller clear its reply flag.
      ST_REL:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a small controller model and
// scoreboard queues for read data and grant order.
module tb_sdram_arbiter;

  localparam int AW      = 21;
  localparam int DW      = 16;
  localparam int TIMEOUT = 255;

  logic          clk_p = 1'b0;
  logic          sdram_reset, sdram_ready;
  logic          m0_stb, m0_we, m0_ack, m0_err;
  logic [1:0]    m0_sel;
  logic [AW:1]   m0_adr;
  logic [DW-1:0] m0_out, m0_dat;
  logic          m1_stb, m1_we, m1_ack, m1_err;
  logic [1:0]    m1_sel;
  logic [AW:1]   m1_adr;
  logic [DW-1:0] m1_out, m1_dat;
  logic          s_stb, s_we, s_ack;
  logic [1:0]    s_sel;
  logic [AW:1]   s_adr;
  logic [DW-1:0] s_out, s_dat;
  logic [1:0]    gnt;

  int errors = 0;
  int checks = 0;

  bit ctrl_auto = 1'b0;
  int ctrl_lat  = 2;
  int ctrl_cnt  = 0;

  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  int            grant_q[$];

  sdram_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(8'd255)) dut (
    .clk_p       (clk_p),
    .sdram_reset (sdram_reset),
    .sdram_ready (sdram_ready),
    .m0_stb      (m0_stb),
    .m0_we       (m0_we),
    .m0_sel      (m0_sel),
    .m0_adr      (m0_adr),
    .m0_out      (m0_out),
    .m0_dat      (m0_dat),
    .m0_ack      (m0_ack),
    .m0_err      (m0_err),
    .m1_stb      (m1_stb),
    .m1_we       (m1_we),
    .m1_sel      (m1_sel),
    .m1_adr      (m1_adr),
    .m1_out      (m1_out),
    .m1_dat      (m1_dat),
    .m1_ack      (m1_ack),
    .m1_err      (m1_err),
    .s_stb       (s_stb),
    .s_we        (s_we),
    .s_sel       (s_sel),
    .s_adr       (s_adr),
    .s_out       (s_out),
    .s_dat       (s_dat),
    .s_ack       (s_ack),
    .gnt         (gnt)
  );

  always #5 clk_p = ~clk_p;

  // Controller model: acks once stb has been high for more than ctrl_lat
  // cycles, holds ack until stb drops, returns data derived from the address.
  always @(posedge clk_p) begin
    #2;
    if (ctrl_auto) begin
      if (s_stb) begin
        ctrl_cnt++;
        s_dat = s_adr[16:1] ^ 16'h5A5A;
        s_ack = (ctrl_cnt > ctrl_lat);
      end else begin
        ctrl_cnt = 0;
        s_ack    = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required $finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_p);
    #1;
  endtask

  task automatic run_master(input int id, input int n);
    for (int t = 0; t < n; t++) begin
      logic [AW:1] a;
      int          k;
      logic        ack_seen;
      a = AW'((id + 1) * 256 + t);
      @(posedge clk_p);
      #1;
      if (id == 0) begin
        m0_adr = a; m0_stb = 1'b1; exp_q0.push_back(a[16:1] ^ 16'h5A5A);
      end else begin
        m1_adr = a; m1_stb = 1'b1; exp_q1.push_back(a[16:1] ^ 16'h5A5A);
      end
      k = 0;
      ack_seen = 1'b0;
      while (!ack_seen && k < 200) begin
        @(negedge clk_p);
        k++;
        ack_seen = (id == 0) ? m0_ack : m1_ack;
      end
      check($sformatf("m%0d_ack_%0d", id, t), ack_seen, 1);
      if (ack_seen) begin
        if (id == 0) check($sformatf("m0_dat_%0d", t), m0_dat, exp_q0.pop_front());
        else         check($sformatf("m1_dat_%0d", t), m1_dat, exp_q1.pop_front());
      end
      @(posedge clk_p);
      #1;
      if (id == 0) m0_stb = 1'b0;
      else         m1_stb = 1'b0;
    end
  endtask

  task automatic monitor_grants(input int n);
    for (int g = 0; g < n; g++) begin
      int   lows;
      int   k;
      int   e;
      logic seen;
      lows = 0;
      k    = 0;
      seen = 1'b0;
      while (!seen && k < 200) begin
        @(negedge clk_p);
        k++;
        if (s_stb) seen = 1'b1;
        else       lows++;
      end
      check($sformatf("grant_%0d_seen", g), seen, 1);
      e = grant_q.pop_front();
      check($sformatf("grant_%0d_owner", g), gnt, (e == 0) ? 2'b01 : 2'b10);
      if (g > 0) check($sformatf("grant_%0d_gap_ge2", g), (lows >= 2), 1);
      k = 0;
      while (s_stb && k < 200) begin
        @(negedge clk_p);
        k++;
      end
      check($sformatf("grant_%0d_end", g), s_stb, 0);
    end
  endtask

  initial begin
    int k;
    sdram_reset = 1'b1; sdram_ready = 1'b0;
    m0_stb = 1'b0; m0_we = 1'b0; m0_sel = 2'b11; m0_adr = '0; m0_out = '0;
    m1_stb = 1'b0; m1_we = 1'b0; m1_sel = 2'b11; m1_adr = '0; m1_out = '0;
    s_ack = 1'b0; s_dat = '0;

    repeat (3) step();
    check("rst_s_stb", s_stb, 0);
    check("rst_gnt", gnt, 2'b00);
    check("rst_m0_err", m0_err, 0);
    check("rst_m0_ack", m0_ack, 0);
    check("rst_m1_err", m1_err, 0);

    // No grant while the controller is still initialising.
    m0_stb = 1'b1; m0_adr = 21'h0ABCD;
    sdram_reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("not_ready_s_stb", s_stb, 0);
      check("not_ready_gnt", gnt, 2'b00);
    end
    sdram_ready = 1'b1;
    #1;
    check("ready_cycle_s_stb", s_stb, 0);
    step();
    check("first_grant_s_stb", s_stb, 1);
    check("first_grant_s_adr", s_adr, 21'h0ABCD);
    check("first_grant_gnt", gnt, 2'b01);
    m0_stb = 1'b0;
    repeat (3) step();

    // m0 read with the controller acking four cycles after stb rose.
    m0_adr = 21'h12345; m0_stb = 1'b1;
    exp_q0.push_back(16'hA5A5);
    step();
    check("rd_s_stb", s_stb, 1);
    check("rd_s_adr", s_adr, 21'h12345);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rd_m0_ack_early", m0_ack, 0);
    end
    step();
    s_ack = 1'b1; s_dat = 16'hA5A5;
    #1;
    check("rd_m0_ack", m0_ack, 1);
    check("rd_m0_dat", m0_dat, exp_q0.pop_front());
    check("rd_m1_ack", m1_ack, 0);
    check("rd_m0_err", m0_err, 0);
    step();
    m0_stb = 1'b0; s_ack = 1'b0;
    repeat (3) step();

    // Simultaneous requesters, three transactions each, from a fresh reset.
    sdram_reset = 1'b1;
    step();
    sdram_reset = 1'b0;
`ifdef SDRAM_ARB_RR_EN
    grant_q = '{0, 1, 0, 1, 0, 1};
`else
    grant_q = '{0, 0, 0, 1, 1, 1};
`endif
    ctrl_auto = 1'b1;
    fork
      run_master(0, 3);
      run_master(1, 3);
      monitor_grants(6);
    join
    ctrl_auto = 1'b0;
    step();
    s_ack = 1'b0;
    check("scoreboard_empty", exp_q0.size() + exp_q1.size() + grant_q.size(), 0);
    repeat (2) step();

    // m1 write; attributes must hold even when m0 requests mid-grant.
    m1_adr = 21'h1F0F0; m1_we = 1'b1; m1_sel = 2'b10; m1_out = 16'hBEEF; m1_stb = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        m0_adr = 21'h00042; m0_we = 1'b0; m0_stb = 1'b1;
        #1;
      end
      check("wr_gnt", gnt, 2'b10);
      check("wr_s_we", s_we, 1);
      check("wr_s_sel", s_sel, 2'b10);
      check("wr_s_out", s_out, 16'hBEEF);
      step();
    end
    s_ack = 1'b1; s_dat = 16'h1234;
    #1;
    check("wr_m1_ack", m1_ack, 1);
    check("wr_m0_ack", m0_ack, 0);
    step();
    m1_stb = 1'b0; s_ack = 1'b0; m1_we = 1'b0;
    #1;
    check("rel_m_s_stb", s_stb, 0);
    step();
    check("rel_m1_s_stb", s_stb, 0);
    check("rel_m1_gnt", gnt, 2'b00);
    step();
    check("rel_m2_gnt", gnt, 2'b00);
    step();
    check("rel_m3_gnt", gnt, 2'b01);
    check("rel_m3_s_adr", s_adr, 21'h00042);
    m0_stb = 1'b0;
    repeat (3) step();

    // Controller never acks: watchdog abort.
    m0_adr = 21'h00777; m0_stb = 1'b1;
    step();
    check("to_s_stb_rise", s_stb, 1);
    k = 0;
    while (!m0_err && k < 300) begin
      step();
      k++;
    end
    check("to_err_latency", k, TIMEOUT);
    check("to_err_s_stb", s_stb, 1);
    check("to_m1_err", m1_err, 0);
    check("to_m0_ack", m0_ack, 0);
    step();
    check("to_next_s_stb", s_stb, 0);
    check("to_next_err", m0_err, 0);
    check("to_next_gnt", gnt, 2'b00);
    m0_stb = 1'b0;
    step();
    check("to_idle_gnt", gnt, 2'b00);
    check("to_idle_s_stb", s_stb, 0);
    repeat (2) step();

    // Asynchronous reset in the middle of a grant.
    m1_adr = 21'h00003; m1_stb = 1'b1;
    step();
    check("ar_gnt", gnt, 2'b10);
    check("ar_s_stb", s_stb, 1);
    #2;
    sdram_reset = 1'b1;
    #1;
    check("ar_async_s_stb", s_stb, 0);
    check("ar_async_gnt", gnt, 2'b00);
    step();
    sdram_reset = 1'b0;
    step();
    check("ar_resume_gnt", gnt, 2'b10);
    check("ar_resume_s_adr", s_adr, 21'h00003);
    m1_stb = 1'b0;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
